// File: rtl/dp_bram_regout.sv
// ---------------------------------------------------------------------------
// dp_bram_regout -- true dual-port block RAM with a read latch and an
// optional output register on each port (two-edge read latency).
//
// Ports:
//   clk                     single rising-edge clock for both ports
//   reset                   synchronous, active-high; clears the latches and
//                           outputs and blocks writes (memory is kept)
//   ena / enb               port enable (memory access + latch update)
//   regcea / regceb         output register clock enable
//   wea / web               write enable (ignored when the port is disabled)
//   addra / addrb           word address, full range, no wrap logic
//   dina / dinb             write data
//   douta / doutb           registered read data
//
// Port A is write-first (latch sees the new data on a write).
// Port B is read-first (latch sees the old contents on a write).
// Both ports writing the same word on the same edge: port A wins.
// A port reading a word the other port writes on the same edge sees the
// pre-write contents.
// ---------------------------------------------------------------------------
module dp_bram_regout #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  regcea,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  enb,
  input  logic                  regceb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Shared storage; deliberately not initialised and not touched by reset.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [DATA_WIDTH-1:0] lat_a;
  logic [DATA_WIDTH-1:0] lat_b;

  // Memory write process. Port B is assigned first so that on a same-address
  // collision the later non-blocking assignment from port A takes effect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (enb && web) begin
        mem[addrb] <= dinb;
      end
      if (ena && wea) begin
        mem[addra] <= dina;
      end
    end
  end

  // Port A read latch: write-first. Reads of mem sample the value from
  // before this edge, which gives cross-port read-old behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_a <= '0;
    end else if (ena) begin
      if (wea) begin
        lat_a <= dina;
      end else begin
        lat_a <= mem[addra];
      end
    end
  end

  // Port B read latch: read-first, so a write still returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_b <= '0;
    end else if (enb) begin
      lat_b <= mem[addrb];
    end
  end

  // Output registers. They load the latch value present before this edge,
  // so regce together with en forwards the previous read, not the new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      douta <= '0;
      doutb <= '0;
    end else begin
      if (regcea) begin
        douta <= lat_a;
      end
      if (regceb) begin
        doutb <= lat_b;
      end
    end
  end

endmodule

// File: tb/tb_dp_bram_regout.sv
// ---------------------------------------------------------------------------
// tb_dp_bram_regout -- self-checking bench for dp_bram_regout.
// A 64K-word instance is driven by directed sequences and random traffic and
// checked every edge against a transaction-level model; a 512-word instance
// covers the small-address configuration.
// ---------------------------------------------------------------------------
module tb_dp_bram_regout;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int SAW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Large instance
  logic          reset, ena, regcea, wea, enb, regceb, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb, douta, doutb;

  // Small instance
  logic           s_reset, s_ena, s_regcea, s_wea, s_enb, s_regceb, s_web;
  logic [SAW-1:0] s_addra, s_addrb;
  logic [DW-1:0]  s_dina, s_dinb, s_douta, s_doutb;

  dp_bram_regout #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .ena(ena), .regcea(regcea), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .enb(enb), .regceb(regceb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
  );

  dp_bram_regout #(.ADDR_WIDTH(SAW), .DATA_WIDTH(DW)) dut_small (
    .clk(clk), .reset(s_reset),
    .ena(s_ena), .regcea(s_regcea), .wea(s_wea), .addra(s_addra), .dina(s_dina), .douta(s_douta),
    .enb(s_enb), .regceb(s_regceb), .web(s_web), .addrb(s_addrb), .dinb(s_dinb), .doutb(s_doutb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // ---------------- reference model (large instance) ----------------
  // Memory holds only words the bench has written; reads of other words
  // make the latch "unknown" and the matching output check is skipped.
  logic [DW-1:0] m_mem [int];
  logic [DW-1:0] m_lat_a, m_lat_b, m_out_a, m_out_b;
  bit            k_lat_a, k_lat_b, k_out_a, k_out_b;

  task automatic model_step();
    logic [DW-1:0] rd_a, rd_b;
    bit            kr_a, kr_b;
    if (reset) begin
      m_lat_a = '0; m_lat_b = '0; m_out_a = '0; m_out_b = '0;
      k_lat_a = 1;  k_lat_b = 1;  k_out_a = 1;  k_out_b = 1;
      return;
    end
    // All reads see the memory as it was before this edge.
    kr_a = m_mem.exists(int'(addra));
    rd_a = kr_a ? m_mem[int'(addra)] : '0;
    kr_b = m_mem.exists(int'(addrb));
    rd_b = kr_b ? m_mem[int'(addrb)] : '0;
    // Outputs take the latch contents from before this edge.
    if (regcea) begin m_out_a = m_lat_a; k_out_a = k_lat_a; end
    if (regceb) begin m_out_b = m_lat_b; k_out_b = k_lat_b; end
    if (ena) begin
      if (wea) begin m_lat_a = dina; k_lat_a = 1; end
      else     begin m_lat_a = rd_a; k_lat_a = kr_a; end
    end
    if (enb) begin m_lat_b = rd_b; k_lat_b = kr_b; end
    // Port A write applied last: it wins a same-address collision.
    if (enb && web) m_mem[int'(addrb)] = dinb;
    if (ena && wea) m_mem[int'(addra)] = dina;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (k_out_a) check("model_douta", {24'd0, douta}, {24'd0, m_out_a});
    if (k_out_b) check("model_doutb", {24'd0, doutb}, {24'd0, m_out_b});
  endtask

  task automatic idle();
    reset = 0; ena = 0; regcea = 0; wea = 0; enb = 0; regceb = 0; web = 0;
  endtask

  task automatic s_idle();
    s_reset = 0; s_ena = 0; s_regcea = 0; s_wea = 0; s_enb = 0; s_regceb = 0; s_web = 0;
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); ena = 1; wea = 1; addra = a; dina = d; tick(); idle();
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); enb = 1; web = 1; addrb = a; dinb = d; tick(); idle();
  endtask

  // Port A read with the specified two-edge latency; returns douta.
  task automatic rd_a_seq(input logic [AW-1:0] a, output logic [DW-1:0] q);
    idle(); ena = 1; addra = a; tick();
    idle(); regcea = 1; tick(); idle();
    q = douta;
  endtask

  task automatic rd_b_seq(input logic [AW-1:0] a, output logic [DW-1:0] q);
    idle(); enb = 1; addrb = a; tick();
    idle(); regceb = 1; tick(); idle();
    q = doutb;
  endtask

  logic [AW-1:0] pool [8];
  logic [DW-1:0] q;

  initial begin
    pool = '{16'h0000, 16'h0001, 16'h0010, 16'h0020, 16'h00FF, 16'h8000, 16'hFFFE, 16'hFFFF};
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    s_addra = '0; s_addrb = '0; s_dina = '0; s_dinb = '0;
    idle(); s_idle();
    k_lat_a = 0; k_lat_b = 0; k_out_a = 0; k_out_b = 0;

    // Reset state
    reset = 1; s_reset = 1;
    tick();
    check("reset_douta", {24'd0, douta}, 32'h0);
    check("reset_doutb", {24'd0, doutb}, 32'h0);
    idle(); s_idle();

    // Port B writes, port A reads with two-edge latency
    wr_b(16'h8000, 8'hA5);
    ena = 1; addra = 16'h8000; tick();
    check("lat31_edgeN", {24'd0, douta}, 32'h0);
    idle(); regcea = 1; tick(); idle();
    check("lat31_edgeN1", {24'd0, douta}, 32'hA5);

    // Port A write-first
    wr_a(16'h0010, 8'h11);
    wr_a(16'h0010, 8'h22);
    regcea = 1; tick(); idle();
    check("wfirst_douta", {24'd0, douta}, 32'h22);
    rd_b_seq(16'h0010, q);
    check("wfirst_b_read", {24'd0, q}, 32'h22);

    // Port B read-first
    wr_b(16'h0020, 8'h33);
    wr_b(16'h0020, 8'h44);
    regceb = 1; tick(); idle();
    check("rfirst_doutb", {24'd0, doutb}, 32'h33);
    rd_b_seq(16'h0020, q);
    check("rfirst_next", {24'd0, q}, 32'h44);

    // Same-address collision at the top address
    wr_a(16'hFFFF, 8'h01);
    ena = 1; wea = 1; addra = 16'hFFFF; dina = 8'h5A;
    enb = 1; web = 1; addrb = 16'hFFFF; dinb = 8'hC3;
    tick(); idle();
    regcea = 1; regceb = 1; tick(); idle();
    check("coll_lat_a", {24'd0, douta}, 32'h5A);
    check("coll_lat_b", {24'd0, doutb}, 32'h01);
    rd_b_seq(16'hFFFF, q);
    check("coll_stored", {24'd0, q}, 32'h5A);

    // Cross-port: B writes X while A reads X -> A sees old word
    enb = 1; web = 1; addrb = 16'h0020; dinb = 8'h99;
    ena = 1; addra = 16'h0020;
    tick(); idle();
    regcea = 1; tick(); idle();
    check("xport_a_old", {24'd0, douta}, 32'h44);

    // regce with en on the same edge forwards the previous latch
    ena = 1; addra = 16'h0010; regcea = 1; tick(); idle();
    check("regce_same_edge", {24'd0, douta}, 32'h44);
    regcea = 1; tick(); idle();
    check("regce_next", {24'd0, douta}, 32'h22);

    // Hold behaviour, then reset with writes suppressed
    wr_a(16'h0030, 8'h77);
    regcea = 1; tick(); idle();
    check("hold_load", {24'd0, douta}, 32'h77);
    for (int i = 0; i < 5; i++) begin
      ena = 1; addra = 16'h0010; tick();
      check("hold_douta", {24'd0, douta}, 32'h77);
    end
    idle();
    reset = 1; ena = 1; wea = 1; addra = 16'h0010; dina = 8'hFF;
    enb = 1; web = 1; addrb = 16'h0030; dinb = 8'hFF; regcea = 1; regceb = 1;
    tick(); idle();
    check("rst_douta", {24'd0, douta}, 32'h0);
    check("rst_doutb", {24'd0, doutb}, 32'h0);
    rd_a_seq(16'h0010, q);
    check("rst_keeps_0010", {24'd0, q}, 32'h22);
    rd_b_seq(16'h0030, q);
    check("rst_keeps_0030", {24'd0, q}, 32'h77);

    // Reset between en edge and regce edge discards the pending read
    reset = 1; tick(); idle();
    ena = 1; addra = 16'h0030; tick(); idle();
    reset = 1; tick(); idle();
    regcea = 1; tick(); idle();
    check("rst_midread", {24'd0, douta}, 32'h0);
    rd_a_seq(16'h0030, q);
    check("after_rst_read", {24'd0, q}, 32'h77);

    // Random traffic on a small address pool to force collisions
    foreach (pool[i]) wr_a(pool[i], DW'($urandom));
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 59) == 0);
      ena    = $urandom_range(0, 1) == 1;
      wea    = $urandom_range(0, 2) == 0;
      regcea = $urandom_range(0, 1) == 1;
      enb    = $urandom_range(0, 1) == 1;
      web    = $urandom_range(0, 2) == 0;
      regceb = $urandom_range(0, 1) == 1;
      addra  = pool[$urandom_range(0, 7)];
      addrb  = pool[$urandom_range(0, 7)];
      dina   = DW'($urandom);
      dinb   = DW'($urandom);
      tick();
    end
    idle();

    // Small instance: top address usable, neighbour untouched
    s_ena = 1; s_wea = 1; s_addra = 9'h0FF; s_dina = 8'h12; tick(); s_idle();
    s_enb = 1; s_web = 1; s_addrb = 9'h1FF; s_dinb = 8'hEE; tick(); s_idle();
    s_ena = 1; s_addra = 9'h1FF; tick(); s_idle();
    s_regcea = 1; tick(); s_idle();
    check("small_top", {24'd0, s_douta}, 32'hEE);
    s_ena = 1; s_addra = 9'h0FF; tick(); s_idle();
    s_regcea = 1; tick(); s_idle();
    check("small_0ff", {24'd0, s_douta}, 32'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
